// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: registered decode with destination history, forwarding distances and load-use stall
module decode_hazard_stage #(
  parameter int         HIST_DEPTH     = 3,
  parameter bit         LOAD_USE_STALL = 1'b1,
  parameter logic [3:0] LINK_REG       = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [3:0]  out_rd,
  output logic [3:0]  out_rs,
  output logic [3:0]  out_rt,
  output logic [3:0]  out_func,
  output logic [15:0] out_imm,
  output logic [19:0] out_offs,
  output logic        out_is_valid,
  output logic [3:0]  out_dest,
  output logic        out_dest_en,
  output logic [2:0]  out_fwd_rs,
  output logic [2:0]  out_fwd_rt
);
  logic                       held_q, held_d;
  logic [31:0]                instr_q, instr_d;
  logic [HIST_DEPTH-1:0]      hv_q, hv_d, hl_q, hl_d;
  logic [HIST_DEPTH-1:0][3:0] hd_q, hd_d;
  logic [3:0]                 op, rd, rs, rt, rt_src, dest;
  logic                       rd_rs, rd_rt, wr_rd, wr_lr, is_ld, stall, issue, accept;
  logic [2:0]                 fwd_rs, fwd_rt;

  // split the held word and classify the opcode; stores carry rd on the second source channel
  always_comb begin
    op     = instr_q[31:28];
    rd     = instr_q[27:24];
    rs     = instr_q[23:20];
    rt     = instr_q[19:16];
    rd_rs  = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    rd_rt  = op inside {4'h0, 4'h2, 4'h9};
    rt_src = (op == 4'h9) ? rd : rt;
    wr_rd  = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h8};
    wr_lr  = op inside {4'h6, 4'h7};
    is_ld  = op == 4'h8;
    dest   = wr_lr ? LINK_REG : rd;
  end

  // nearest matching history slot wins; register 0 never forwards
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      fwd_rs = (held_q && rd_rs && rs != 4'd0 && hv_q[i] && hd_q[i] == rs) ? 3'(i + 1) : fwd_rs;
      fwd_rt = (held_q && rd_rt && rt_src != 4'd0 && hv_q[i] && hd_q[i] == rt_src) ? 3'(i + 1) : fwd_rt;
    end
  end

  assign stall        = LOAD_USE_STALL && hl_q[0] && (fwd_rs == 3'd1 || fwd_rt == 3'd1);
  assign out_valid    = held_q && !stall && !flush;
  assign issue        = out_valid && out_ready;
  assign in_ready     = !flush && (!held_q || issue);
  assign accept       = in_valid && in_ready;
  assign held_d       = !flush && (accept || (held_q && !issue));
  assign instr_d      = accept ? in_instr : instr_q;
  assign out_op       = op;
  assign out_rd       = rd;
  assign out_rs       = rs;
  assign out_rt       = rt;
  assign out_func     = instr_q[3:0];
  assign out_imm      = instr_q[15:0];
  assign out_offs     = instr_q[19:0];
  assign out_is_valid = held_q && !(op inside {4'hC, 4'hD, 4'hE});
  assign out_dest     = dest;
  assign out_dest_en  = held_q && (wr_rd || wr_lr) && dest != 4'd0;
  assign out_fwd_rs   = fwd_rs;
  assign out_fwd_rt   = fwd_rt;

  // history shifts on every advance; a cycle without issue enters as a bubble
  always_comb begin
    hv_d = hv_q;
    hl_d = hl_q;
    hd_d = hd_q;
    if (out_ready) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hv_d[i] = hv_q[i-1];
        hl_d[i] = hl_q[i-1];
        hd_d[i] = hd_q[i-1];
      end
      hv_d[0] = issue && out_dest_en;
      hl_d[0] = issue && is_ld;
      hd_d[0] = dest;
    end
  end

  // decode register and history state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q  <= 1'b0;
      instr_q <= '0;
      hv_q    <= '0;
      hl_q    <= '0;
      hd_q    <= '0;
    end else begin
      held_q  <= held_d;
      instr_q <= instr_d;
      hv_q    <= hv_d;
      hl_q    <= hl_d;
      hd_q    <= hd_d;
    end
  end
endmodule

// File: tb/tb_decode_hazard_stage.sv
// tb_decode_hazard_stage: table vectors, hand sequences and random stimulus against a queue-based model
module tb_decode_hazard_stage;
  localparam int HD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0, out_is_valid, out_dest_en;
  logic [31:0] in_instr = 0;
  logic [3:0]  out_op, out_rd, out_rs, out_rt, out_func, out_dest;
  logic [15:0] out_imm;
  logic [19:0] out_offs;
  logic [2:0]  out_fwd_rs, out_fwd_rt;

  logic        b_in_valid = 0, b_in_ready, b_flush = 0, b_out_valid, b_out_ready = 0, b_out_is_valid, b_out_dest_en;
  logic [31:0] b_in_instr = 0;
  logic [3:0]  b_out_op, b_out_rd, b_out_rs, b_out_rt, b_out_func, b_out_dest;
  logic [15:0] b_out_imm;
  logic [19:0] b_out_offs;
  logic [2:0]  b_out_fwd_rs, b_out_fwd_rt;

  decode_hazard_stage #(.HIST_DEPTH(HD), .LOAD_USE_STALL(1'b1), .LINK_REG(4'd15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_rs(out_rs), .out_rt(out_rt), .out_func(out_func), .out_imm(out_imm), .out_offs(out_offs),
    .out_is_valid(out_is_valid), .out_dest(out_dest), .out_dest_en(out_dest_en),
    .out_fwd_rs(out_fwd_rs), .out_fwd_rt(out_fwd_rt));

  decode_hazard_stage #(.HIST_DEPTH(HD), .LOAD_USE_STALL(1'b0), .LINK_REG(4'd15)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_op(b_out_op), .out_rd(b_out_rd),
    .out_rs(b_out_rs), .out_rt(b_out_rt), .out_func(b_out_func), .out_imm(b_out_imm), .out_offs(b_out_offs),
    .out_is_valid(b_out_is_valid), .out_dest(b_out_dest), .out_dest_en(b_out_dest_en),
    .out_fwd_rs(b_out_fwd_rs), .out_fwd_rt(b_out_fwd_rt));

  typedef struct {
    bit v;
    logic [3:0] d;
    bit ld;
  } slot_t;

  typedef struct {
    bit iv;
    logic [31:0] w;
    bit fl;
    bit rdy;
    bit ov;
    logic [2:0] frs;
    logic [2:0] frt;
    logic [3:0] dst;
    bit den;
    bit isv;
  } vec_t;

  // per opcode: sources 0 none, 1 rs, 2 rs+rt, 3 rs+rd; destination 0 none, 1 rd, 2 link
  int src_kind [16] = '{2, 1, 2, 1, 0, 1, 0, 1, 1, 3, 1, 1, 0, 0, 0, 0};
  int dst_kind [16] = '{1, 1, 1, 1, 0, 0, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0};

  slot_t       hist[$];
  bit          m_held;
  logic [31:0] m_instr;
  int          vec = 0;
  int          bad = 0;
  vec_t        tab[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic int fwd_of(input logic [3:0] r);
    if (r == 4'd0) return 0;
    for (int k = 0; k < hist.size(); k++)
      if (hist[k].v && hist[k].d == r) return k + 1;
    return 0;
  endfunction

  task automatic model_reset();
    slot_t e;
    e.v = 0; e.d = 0; e.ld = 0;
    hist.delete();
    for (int k = 0; k < HD; k++) hist.push_back(e);
    m_held = 0;
    m_instr = 0;
  endtask

  function automatic vec_t mk(input bit iv, input logic [31:0] w, input bit fl, input bit rdy, input bit ov,
                              input int frs, input int frt, input int dst, input bit den, input bit isv);
    vec_t v;
    v.iv = iv; v.w = w; v.fl = fl; v.rdy = rdy; v.ov = ov;
    v.frs = 3'(frs); v.frt = 3'(frt); v.dst = 4'(dst); v.den = den; v.isv = isv;
    return v;
  endfunction

  task automatic step(input vec_t v, input bit tab_chk);
    logic [3:0] op, rd, rs, rt, dst;
    int e_rs, e_rt;
    bit den, st, ov, iss, ir, def;
    slot_t s;
    in_valid = v.iv; in_instr = v.w; flush = v.fl; out_ready = v.rdy;
    op = m_instr[31:28]; rd = m_instr[27:24]; rs = m_instr[23:20]; rt = m_instr[19:16];
    e_rs = (m_held && src_kind[op] != 0) ? fwd_of(rs) : 0;
    e_rt = (m_held && src_kind[op] >= 2) ? fwd_of(src_kind[op] == 3 ? rd : rt) : 0;
    dst = (dst_kind[op] == 2) ? 4'd15 : rd;
    den = m_held && dst_kind[op] != 0 && dst != 4'd0;
    def = m_held && op != 4'hC && op != 4'hD && op != 4'hE;
    st = hist[0].ld && (e_rs == 1 || e_rt == 1);
    ov = m_held && !st && !v.fl;
    iss = ov && v.rdy;
    ir = !v.fl && (!m_held || iss);
    @(negedge clk);
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, ir);
    chk("fields", {out_op, out_rd, out_rs, out_rt, out_imm}, m_instr);
    chk("func_offs", {out_offs, out_func}, {m_instr[19:0], m_instr[3:0]});
    chk("fwd", {out_fwd_rs, out_fwd_rt}, {3'(e_rs), 3'(e_rt)});
    chk("dest", {out_is_valid, out_dest_en, out_dest}, {def, den, dst});
    if (tab_chk) begin
      chk("tab_valid", out_valid, v.ov);
      chk("tab_fwd", {out_fwd_rs, out_fwd_rt}, {v.frs, v.frt});
      chk("tab_dest", {out_is_valid, out_dest_en, out_dest}, {v.isv, v.den, v.dst});
    end
    if (v.rdy) begin
      s.v = iss && den; s.d = dst; s.ld = iss && op == 4'h8;
      hist.push_front(s);
      void'(hist.pop_back());
    end
    if (v.fl) m_held = 0;
    else if (v.iv && ir) begin m_held = 1; m_instr = v.w; end
    else if (iss) m_held = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    tab.push_back(mk(1, 32'h0123_0000, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 32'h0415_0000, 0, 1, 1, 0, 0, 1, 1, 1));
    tab.push_back(mk(0, 32'h0,         0, 1, 1, 1, 0, 4, 1, 1));
    tab.push_back(mk(1, 32'h8410_0008, 0, 1, 0, 0, 0, 4, 0, 0));
    tab.push_back(mk(1, 32'h0544_0000, 0, 1, 1, 3, 0, 4, 1, 1));
    tab.push_back(mk(0, 32'h0,         0, 1, 0, 1, 1, 5, 1, 1));
    tab.push_back(mk(0, 32'h0,         0, 1, 1, 2, 2, 5, 1, 1));
    tab.push_back(mk(1, 32'h0612_0000, 0, 1, 0, 0, 0, 5, 0, 0));
    tab.push_back(mk(1, 32'h0700_0000, 0, 1, 1, 0, 0, 6, 1, 1));
    tab.push_back(mk(1, 32'h0800_0000, 0, 1, 1, 0, 0, 7, 1, 1));
    tab.push_back(mk(1, 32'h0960_0000, 0, 1, 1, 0, 0, 8, 1, 1));
    tab.push_back(mk(1, 32'h0612_0000, 0, 1, 1, 3, 0, 9, 1, 1));
    tab.push_back(mk(1, 32'h0700_0000, 0, 1, 1, 0, 0, 6, 1, 1));
    tab.push_back(mk(1, 32'h0800_0000, 0, 1, 1, 0, 0, 7, 1, 1));
    tab.push_back(mk(1, 32'h0A00_0000, 0, 1, 1, 0, 0, 8, 1, 1));
    tab.push_back(mk(1, 32'h0960_0000, 0, 1, 1, 0, 0, 10, 1, 1));
    tab.push_back(mk(1, 32'h6000_0100, 0, 1, 1, 0, 0, 9, 1, 1));
    tab.push_back(mk(1, 32'h50F0_0000, 0, 1, 1, 0, 0, 15, 1, 1));
    tab.push_back(mk(1, 32'h1000_0005, 0, 1, 1, 1, 0, 0, 0, 1));
    tab.push_back(mk(1, 32'h0500_0000, 0, 1, 1, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 32'hC123_0000, 0, 1, 1, 0, 0, 5, 1, 1));
    tab.push_back(mk(0, 32'h0,         0, 1, 1, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 32'h0256_0000, 0, 1, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 32'h0300_0000, 0, 0, 1, 3, 0, 2, 1, 1));
    tab.push_back(mk(1, 32'h0300_0000, 0, 0, 1, 3, 0, 2, 1, 1));
    tab.push_back(mk(1, 32'h0300_0000, 0, 0, 1, 3, 0, 2, 1, 1));
    tab.push_back(mk(1, 32'h0300_0000, 0, 1, 1, 3, 0, 2, 1, 1));
    tab.push_back(mk(1, 32'h0400_0000, 1, 1, 0, 0, 0, 3, 1, 1));
    tab.push_back(mk(1, 32'h0420_0000, 0, 1, 0, 0, 0, 3, 0, 0));
    tab.push_back(mk(0, 32'h0,         0, 1, 1, 3, 0, 4, 1, 1));

    // load-use without stalling, on the second instance while the first stays in reset
    repeat (2) @(posedge clk);
    #1 b_rst_n = 1;
    b_in_valid = 1; b_in_instr = 32'h8410_0008; b_out_ready = 1;
    @(posedge clk); #1;
    b_in_instr = 32'h0544_0000;
    @(posedge clk); #1;
    b_in_valid = 0;
    @(negedge clk);
    chk("nostall_valid", b_out_valid, 1);
    chk("nostall_fwd", {b_out_fwd_rs, b_out_fwd_rt}, {3'd1, 3'd1});
    chk("nostall_dest", b_out_dest, 4'd5);
    @(posedge clk); #1;

    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < tab.size(); i++) step(tab[i], 1);

    // asynchronous reset while an instruction is held and r3 sits in history
    step(mk(1, 32'h0312_0000, 0, 1, 0, 0, 0, 0, 0, 0), 0);
    step(mk(1, 32'h0700_0000, 0, 1, 0, 0, 0, 0, 0, 0), 0);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dest_en", {out_is_valid, out_dest_en}, 2'b00);
    chk("rst_fields", {out_op, out_rd, out_rs, out_rt, out_imm}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    step(mk(1, 32'h0430_0000, 0, 1, 0, 0, 0, 0, 0, 0), 1);
    step(mk(0, 32'h0,         0, 1, 1, 0, 0, 4, 1, 1), 1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
           4'($urandom_range(0, 5)), 16'($urandom)};
      step(mk($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              0, 0, 0, 0, 0, 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
